// File: rtl/conv_pkg.sv
// Shared types and frame/kernel constants for the streaming 3x3 convolution engine
// and its layer sequencer.
package conv_pkg;

  localparam int unsigned IMG_W      = 128;
  localparam int unsigned IMG_H      = 128;
  localparam int unsigned FRAME_PIX  = IMG_W * IMG_H;
  localparam int unsigned KTAPS      = 9;
  localparam int unsigned PIX_DATA_W = 16;
  localparam int unsigned TAP_W      = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    START,
    RUN,
    NEXT,
    DONE
  } seq_state_e;

endpackage

// File: rtl/conv_wload.sv
// Kernel weight loader: reads KTAPS consecutive weights and writes each into the
// engine one cycle later. The read address keeps running across kernels.
module conv_wload
  import conv_pkg::*;
#(
  parameter int unsigned WADDR_W = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [WADDR_W-1:0]    addr_i,
  output logic [WADDR_W-1:0]    addr_o,
  output logic                  done_o,
  output logic                  rd_en_o,
  input  logic [PIX_DATA_W-1:0] rd_data_i,
  output logic                  we_o,
  output logic [TAP_W-1:0]      idx_o,
  output logic [PIX_DATA_W-1:0] data_o
);

  logic               rd_q;
  logic               we_q;
  logic [TAP_W-1:0]   tap_q;
  logic [TAP_W-1:0]   idx_q;
  logic [WADDR_W-1:0] addr_q;

  // Read strobe runs for KTAPS cycles; the engine write trails it by one cycle.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_q   <= 1'b0;
      we_q   <= 1'b0;
      tap_q  <= '0;
      idx_q  <= '0;
      addr_q <= '0;
    end else if (abort_i) begin
      rd_q  <= 1'b0;
      we_q  <= 1'b0;
      tap_q <= '0;
    end else begin
      we_q  <= rd_q;
      idx_q <= tap_q;
      if (start_i) begin
        rd_q   <= 1'b1;
        tap_q  <= '0;
        addr_q <= addr_i;
      end else if (rd_q) begin
        addr_q <= addr_q + WADDR_W'(1);
        if (tap_q == TAP_W'(KTAPS - 1)) begin
          rd_q <= 1'b0;
        end else begin
          tap_q <= tap_q + TAP_W'(1);
        end
      end
    end
  end

  assign addr_o  = addr_q;
  assign rd_en_o = rd_q;
  assign we_o    = we_q;
  assign idx_o   = idx_q;
  // Memory data arrives with one cycle latency, aligned with the delayed write.
  assign data_o  = rd_data_i;
  assign done_o  = we_q && (idx_q == TAP_W'(KTAPS - 1));

endmodule

// File: rtl/conv_layer_sequencer.sv
// Layer controller: per (oc, ic) pass loads a kernel, arms the accumulator, starts a
// frame and watches the output stream. CONV_SEQ_PERF_EN adds RUN/stall counters.
module conv_layer_sequencer #(
  parameter int unsigned CH_W      = 8,
  parameter int unsigned WADDR_W   = 16,
  parameter int unsigned FRAME_PIX = conv_pkg::FRAME_PIX,
  parameter int unsigned PIX_W     = 15
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           cfg_start,
  input  logic                           cfg_abort,
  input  logic [CH_W-1:0]                cfg_num_ic,
  input  logic [CH_W-1:0]                cfg_num_oc,
  input  logic [WADDR_W-1:0]             cfg_wbase,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [CH_W-1:0]                cur_ic,
  output logic [CH_W-1:0]                cur_oc,
  output logic                           wmem_rd_en,
  output logic [WADDR_W-1:0]             wmem_addr,
  input  logic [conv_pkg::PIX_DATA_W-1:0] wmem_rd_data,
  output logic                           eng_w_we,
  output logic [conv_pkg::TAP_W-1:0]     eng_w_idx,
  output logic [conv_pkg::PIX_DATA_W-1:0] eng_w_data,
  output logic                           eng_acc_clr,
  output logic                           eng_acc_last,
  output logic                           eng_frm_start,
`ifdef CONV_SEQ_PERF_EN
  output logic [31:0]                    perf_run_cyc,
  output logic [31:0]                    perf_stall_cyc,
`endif
  input  logic                           obs_tvalid,
  input  logic                           obs_tready,
  input  logic                           obs_tlast
);

  import conv_pkg::*;

  seq_state_e         state_q, state_d;
  logic [CH_W-1:0]    ic_q, ic_d, oc_q, oc_d;
  logic [CH_W-1:0]    ic_last_q, ic_last_d, oc_last_q, oc_last_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d, done_q, done_d, frm_q, frm_d;
  logic               clr_q, clr_d, last_q, last_d;
  logic               abort_act, beat, in_pass;
  logic               wl_start, wl_done;
  logic [WADDR_W-1:0] wl_addr_in;

  assign abort_act  = cfg_abort && (state_q != IDLE);
  assign beat       = obs_tvalid && obs_tready;
  assign wl_start   = (state_d == LOAD_W) && (state_q != LOAD_W);
  assign wl_addr_in = (state_q == IDLE) ? cfg_wbase : wmem_addr;

  // Next state, pass bookkeeping and registered-output next values.
  always_comb begin
    state_d   = state_q;
    ic_d      = ic_q;
    oc_d      = oc_q;
    ic_last_d = ic_last_q;
    oc_last_d = oc_last_q;
    pix_d     = pix_q;
    err_d     = err_q;
    if (abort_act) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cfg_start && !cfg_abort) begin
            err_d     = 1'b0;
            ic_d      = '0;
            oc_d      = '0;
            ic_last_d = (cfg_num_ic == '0) ? '0 : cfg_num_ic - CH_W'(1);
            oc_last_d = (cfg_num_oc == '0) ? '0 : cfg_num_oc - CH_W'(1);
            state_d   = LOAD_W;
          end
        end
        LOAD_W: if (wl_done) state_d = START;
        START: begin
          pix_d   = '0;
          state_d = RUN;
        end
        RUN: begin
          if (beat) begin
            if (pix_q == PIX_W'(FRAME_PIX - 1)) begin
              if (obs_tlast) begin
                state_d = NEXT;
              end else begin
                err_d   = 1'b1;
                state_d = DONE;
              end
            end else if (obs_tlast) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              pix_d = pix_q + PIX_W'(1);
            end
          end
        end
        NEXT: begin
          if (ic_q != ic_last_q) begin
            ic_d    = ic_q + CH_W'(1);
            state_d = LOAD_W;
          end else begin
            ic_d    = '0;
            oc_d    = oc_q + CH_W'(1);
            state_d = (oc_q == oc_last_q) ? DONE : LOAD_W;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    in_pass = (state_d == LOAD_W) || (state_d == START) || (state_d == RUN);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    frm_d   = (state_d == START);
    clr_d   = in_pass && (ic_d == '0);
    last_d  = in_pass && (ic_d == ic_last_d);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      ic_q      <= '0;
      oc_q      <= '0;
      ic_last_q <= '0;
      oc_last_q <= '0;
      pix_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      frm_q     <= 1'b0;
      clr_q     <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ic_q      <= ic_d;
      oc_q      <= oc_d;
      ic_last_q <= ic_last_d;
      oc_last_q <= oc_last_d;
      pix_q     <= pix_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      frm_q     <= frm_d;
      clr_q     <= clr_d;
      last_q    <= last_d;
    end
  end

  conv_wload #(
    .WADDR_W (WADDR_W)
  ) u_wload (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .start_i   (wl_start),
    .abort_i   (abort_act),
    .addr_i    (wl_addr_in),
    .addr_o    (wmem_addr),
    .done_o    (wl_done),
    .rd_en_o   (wmem_rd_en),
    .rd_data_i (wmem_rd_data),
    .we_o      (eng_w_we),
    .idx_o     (eng_w_idx),
    .data_o    (eng_w_data)
  );

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign cur_ic        = ic_q;
  assign cur_oc        = oc_q;
  assign eng_acc_clr   = clr_q;
  assign eng_acc_last  = last_q;
  assign eng_frm_start = frm_q;

`ifdef CONV_SEQ_PERF_EN
  logic [31:0] run_cyc_q, stall_cyc_q;

  // Saturating RUN-cycle and stall counters, cleared when a layer is accepted.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      run_cyc_q   <= '0;
      stall_cyc_q <= '0;
    end else if ((state_q == IDLE) && cfg_start && !cfg_abort) begin
      run_cyc_q   <= '0;
      stall_cyc_q <= '0;
    end else if (state_q == RUN) begin
      if (run_cyc_q != '1) run_cyc_q <= run_cyc_q + 32'(1);
      if (obs_tvalid && !obs_tready && (stall_cyc_q != '1)) stall_cyc_q <= stall_cyc_q + 32'(1);
    end
  end

  assign perf_run_cyc   = run_cyc_q;
  assign perf_stall_cyc = stall_cyc_q;
`endif

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Scoreboard bench for conv_layer_sequencer: a loop-nest reference model queues the
// expected reads, weight writes, frame starts and done pulses; a monitor pops them.
module tb_conv_layer_sequencer;

  localparam int unsigned FP     = 512;
  localparam int unsigned PW     = 9;
  localparam int              BUDGET = 30000;

  logic        aclk;
  logic        aresetn;
  logic        cfg_start, cfg_abort;
  logic [7:0]  cfg_num_ic, cfg_num_oc;
  logic [15:0] cfg_wbase;
  logic        busy, done, err;
  logic [7:0]  cur_ic, cur_oc;
  logic        wmem_rd_en;
  logic [15:0] wmem_addr, wmem_rd_data;
  logic        eng_w_we;
  logic [3:0]  eng_w_idx;
  logic [15:0] eng_w_data;
  logic        eng_acc_clr, eng_acc_last, eng_frm_start;
  logic        obs_tvalid, obs_tready, obs_tlast;
`ifdef CONV_SEQ_PERF_EN
  logic [31:0] perf_run_cyc, perf_stall_cyc;
`endif

  conv_layer_sequencer #(
    .CH_W      (8),
    .WADDR_W   (16),
    .FRAME_PIX (FP),
    .PIX_W     (PW)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_start     (cfg_start),
    .cfg_abort     (cfg_abort),
    .cfg_num_ic    (cfg_num_ic),
    .cfg_num_oc    (cfg_num_oc),
    .cfg_wbase     (cfg_wbase),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .cur_ic        (cur_ic),
    .cur_oc        (cur_oc),
    .wmem_rd_en    (wmem_rd_en),
    .wmem_addr     (wmem_addr),
    .wmem_rd_data  (wmem_rd_data),
    .eng_w_we      (eng_w_we),
    .eng_w_idx     (eng_w_idx),
    .eng_w_data    (eng_w_data),
    .eng_acc_clr   (eng_acc_clr),
    .eng_acc_last  (eng_acc_last),
    .eng_frm_start (eng_frm_start),
`ifdef CONV_SEQ_PERF_EN
    .perf_run_cyc  (perf_run_cyc),
    .perf_stall_cyc(perf_stall_cyc),
`endif
    .obs_tvalid    (obs_tvalid),
    .obs_tready    (obs_tready),
    .obs_tlast     (obs_tlast)
  );

  typedef struct {
    int ic;
    int oc;
    bit clr;
    bit last;
  } frm_t;

  int   checks = 0;
  int   failures = 0;
  int   exp_rd[$];
  int   exp_w[$];
  frm_t exp_frm[$];
  bit   exp_done[$];

  int   stall_pct = 0;
  int   valid_pct = 100;
  int   err_beat  = -1;
  bit   eng_act   = 1'b0;
  int   eng_beat  = 0;
  int   stalls_seen = 0;
  int   run_seen    = 0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Weight memory: each location holds its own address, one-cycle read latency.
  initial begin : wmem
    bit          rd;
    logic [15:0] a;
    wmem_rd_data = '0;
    forever begin
      @(posedge aclk);
      rd = wmem_rd_en;
      a  = wmem_addr;
      #1;
      if (rd) wmem_rd_data = a;
    end
  end

  // Engine output stream: FP beats per frame, tlast on the final (or the injected) beat.
  initial begin : engine
    int beat;
    bit act;
    act = 1'b0;
    beat = 0;
    obs_tvalid = 1'b0;
    obs_tready = 1'b0;
    obs_tlast  = 1'b0;
    forever begin
      @(posedge aclk);
      if (act) begin
        run_seen++;
        if (obs_tvalid && !obs_tready) stalls_seen++;
        if (obs_tvalid && obs_tready) begin
          beat++;
          if (obs_tlast) act = 1'b0;
        end
        if (cfg_abort) act = 1'b0;
      end
      if (eng_frm_start) begin
        act  = 1'b1;
        beat = 0;
      end
      #1;
      eng_act  = act;
      eng_beat = beat;
      if (act) begin
        obs_tvalid = ($urandom_range(99) < 32'(valid_pct));
        obs_tready = ($urandom_range(99) >= 32'(stall_pct));
        obs_tlast  = (beat == ((err_beat >= 0) ? err_beat : int'(FP) - 1));
      end else begin
        obs_tvalid = 1'b0;
        obs_tready = 1'b0;
        obs_tlast  = 1'b0;
      end
    end
  end

  // Monitor: every DUT strobe must match the head of its expectation queue.
  initial begin : monitor
    int   e;
    frm_t f;
    bit   d;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        if (wmem_rd_en) begin
          chk("rd_expected", exp_rd.size() > 0, 1);
          if (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            chk("rd_addr", wmem_addr, e);
          end
        end
        if (eng_w_we) begin
          chk("wr_expected", exp_w.size() > 0, 1);
          if (exp_w.size() > 0) begin
            e = exp_w.pop_front();
            chk("wr_idx_data", {eng_w_idx, eng_w_data}, e);
          end
        end
        if (eng_frm_start) begin
          chk("frm_expected", exp_frm.size() > 0, 1);
          if (exp_frm.size() > 0) begin
            f = exp_frm.pop_front();
            chk("frm_ic", cur_ic, f.ic);
            chk("frm_oc", cur_oc, f.oc);
            chk("frm_acc_clr", eng_acc_clr, f.clr);
            chk("frm_acc_last", eng_acc_last, f.last);
          end
        end
        if (done) begin
          chk("done_expected", exp_done.size() > 0, 1);
          if (exp_done.size() > 0) begin
            d = exp_done.pop_front();
            chk("done_err", err, d);
          end
        end
      end
    end
  end

  // Reference model: the layer is a plain (oc, ic) loop nest over contiguous kernels.
  task automatic push_model(input int nic, input int noc, input int wb, input int max_pass,
                            input bit with_done, input bit derr);
    int n_ic, n_oc, k, a;
    frm_t f;
    n_ic = (nic == 0) ? 1 : nic;
    n_oc = (noc == 0) ? 1 : noc;
    k = 0;
    for (int oc = 0; oc < n_oc; oc++) begin
      for (int ic = 0; ic < n_ic; ic++) begin
        if (k < max_pass) begin
          for (int t = 0; t < 9; t++) begin
            a = (wb + k * 9 + t) & 16'hFFFF;
            exp_rd.push_back(a);
            exp_w.push_back((t << 16) | a);
          end
          f.ic = ic;
          f.oc = oc;
          f.clr = (ic == 0);
          f.last = (ic == n_ic - 1);
          exp_frm.push_back(f);
        end
        k++;
      end
    end
    if (with_done) exp_done.push_back(derr);
  endtask

  task automatic start_layer(input int nic, input int noc, input int wb);
    @(posedge aclk);
    #1;
    cfg_num_ic = 8'(nic);
    cfg_num_oc = 8'(noc);
    cfg_wbase  = 16'(wb);
    cfg_start  = 1'b1;
    @(posedge aclk);
    #1;
    cfg_start  = 1'b0;
    cfg_num_ic = 8'($urandom);
    cfg_num_oc = 8'($urandom);
    cfg_wbase  = 16'($urandom);
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge aclk);
      if (!busy) break;
    end
    chk({name, "_finished"}, busy, 0);
    chk({name, "_rd_left"}, exp_rd.size(), 0);
    chk({name, "_wr_left"}, exp_w.size(), 0);
    chk({name, "_frm_left"}, exp_frm.size(), 0);
    chk({name, "_done_left"}, exp_done.size(), 0);
  endtask

  task automatic run_layer(input string name, input int nic, input int noc, input int wb);
    push_model(nic, noc, wb, 1 << 20, 1'b1, 1'b0);
    start_layer(nic, noc, wb);
    wait_idle(name);
  endtask

  initial begin : stimulus
    int nic, noc, wb, s0, r0;
    aresetn    = 1'b0;
    cfg_start  = 1'b0;
    cfg_abort  = 1'b0;
    cfg_num_ic = '0;
    cfg_num_oc = '0;
    cfg_wbase  = '0;
    repeat (5) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cur_ic", cur_ic, 0);
    chk("rst_cur_oc", cur_oc, 0);
    chk("rst_rd_en", wmem_rd_en, 0);
    chk("rst_addr", wmem_addr, 0);
    chk("rst_w_we", eng_w_we, 0);
    chk("rst_frm_start", eng_frm_start, 0);
    chk("rst_acc", {eng_acc_clr, eng_acc_last}, 0);

    // Single 1x1 pass at base 0x0100.
    run_layer("l1x1", 1, 1, 16'h0100);

    // 3x2 layer at base 0; a start pulse mid-layer must be ignored.
    push_model(3, 2, 0, 1 << 20, 1'b1, 1'b0);
    start_layer(3, 2, 0);
    repeat (700) @(posedge aclk);
    #1;
    cfg_num_ic = 8'd5;
    cfg_wbase  = 16'h2222;
    cfg_start  = 1'b1;
    @(posedge aclk);
    #1;
    cfg_start  = 1'b0;
    wait_idle("l3x2");

    // Random ready backpressure and valid gaps.
    stall_pct = 50;
    valid_pct = 80;
    run_layer("stall", 1, 1, 16'h0100);

    // Early tlast: error, done pulse, sticky err until the next start.
    stall_pct = 0;
    valid_pct = 100;
    err_beat  = 99;
    push_model(2, 1, 16'h0300, 1, 1'b1, 1'b1);
    start_layer(2, 1, 16'h0300);
    wait_idle("early_tlast");
    repeat (5) @(negedge aclk);
    chk("err_sticky", err, 1);
    err_beat = -1;
    push_model(1, 1, 16'h0010, 1 << 20, 1'b1, 1'b0);
    start_layer(1, 1, 16'h0010);
    chk("err_cleared", err, 0);
    wait_idle("after_err");

    // Abort on the 5th accepted beat of the first pass.
    push_model(2, 2, 16'h0040, 1, 1'b0, 1'b0);
    start_layer(2, 2, 16'h0040);
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge aclk);
      if (eng_act && eng_beat == 4) break;
    end
    chk("abort_reached_beat5", eng_act && (eng_beat == 4), 1);
    cfg_abort = 1'b1;
    @(posedge aclk);
    #1;
    cfg_abort = 1'b0;
    @(negedge aclk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_strobes", {wmem_rd_en, eng_w_we, eng_frm_start, eng_acc_clr, eng_acc_last}, 0);
    wait_idle("abort");
    run_layer("after_abort", 2, 2, 16'h0040);

    // Start and abort together in IDLE: abort wins.
    @(posedge aclk);
    #1;
    cfg_num_ic = 8'd1;
    cfg_num_oc = 8'd1;
    cfg_start  = 1'b1;
    cfg_abort  = 1'b1;
    @(posedge aclk);
    #1;
    cfg_start  = 1'b0;
    cfg_abort  = 1'b0;
    @(negedge aclk);
    chk("start_abort_busy", busy, 0);
    repeat (20) @(negedge aclk);
    chk("start_abort_idle", busy, 0);

    // Randomized layers.
    for (int r = 0; r < 3; r++) begin
      nic = int'($urandom_range(3, 1));
      noc = int'($urandom_range(2, 1));
      wb  = int'($urandom_range(16'hFFFF, 0));
      stall_pct = int'($urandom_range(40, 0));
      valid_pct = int'($urandom_range(100, 60));
      run_layer("random", nic, noc, wb);
    end

    // Zero channel counts behave as 1x1.
    stall_pct = 30;
    valid_pct = 90;
    s0 = stalls_seen;
    r0 = run_seen;
    run_layer("zero_counts", 0, 0, 16'h0500);
`ifdef CONV_SEQ_PERF_EN
    chk("perf_stall_cyc", perf_stall_cyc, stalls_seen - s0);
    chk("perf_run_cyc", perf_run_cyc, run_seen - r0);
`else
    chk("zero_counts_stall_bookkeeping", (stalls_seen - s0) <= (run_seen - r0), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
- Layer-level controller for the 3x3 streaming convolution engine (128x128 frames, 16-bit pixels).
- For each output channel and each input channel, it does four things in order:
  - loads the 9 kernel weights from weight memory into the engine;
  - arms the accumulator (clear on the first input channel, finalize on the last);
  - starts one frame pass;
  - monitors the engine's output AXI-Stream until frame end.
- Sits between the PS-side control registers and the conv engine / DMA.

Parameters:
- CH_W, 8: width of channel-count fields (max 255 channels).
- WADDR_W, 16: weight memory address width.
- KTAPS, 9: weights per kernel.
- FRAME_PIX, 16384: output beats per frame (128x128).
- PIX_W, 15: width of the beat counter (holds FRAME_PIX-1).

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- cfg_start  in  1  one-cycle start pulse; ignored unless IDLE
- cfg_abort  in  1  abort current layer
- cfg_num_ic  in  CH_W  input channels, 0 treated as 1
- cfg_num_oc  in  CH_W  output channels, 0 treated as 1
- cfg_wbase  in  WADDR_W  weight base address
- busy  out  1  high when not IDLE
- done  out  1  one-cycle pulse at layer end
- err  out  1  sticky framing error; cleared by cfg_start
- cur_ic  out  CH_W  current input channel
- cur_oc  out  CH_W  current output channel
- wmem_rd_en  out  1  weight memory read strobe
- wmem_addr  out  WADDR_W  weight read address
- wmem_rd_data  in  16  weight data, 1-cycle read latency
- eng_w_we  out  1  write weight into engine
- eng_w_idx  out  4  tap index 0..8
- eng_w_data  out  16  weight value
- eng_acc_clr  out  1  level; engine overwrites partial sums this pass
- eng_acc_last  out  1  level; engine applies final output this pass
- eng_frm_start  out  1  one-cycle pulse; engine/DMA begin a frame
- obs_tvalid  in  1  engine m_axis_tvalid (monitor only)
- obs_tready  in  1  engine m_axis_tready (monitor only)
- obs_tlast  in  1  engine m_axis_tlast (monitor only)

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Counters, wmem_addr and err are 0.
- Configuration latch: cfg_num_ic, cfg_num_oc and cfg_wbase are latched on an accepted cfg_start. They are not re-sampled mid-layer.
- State IDLE: on cfg_start, clear err, set ic=oc=0, addr=cfg_wbase, go LOAD_W.
- State LOAD_W:
  - Issues wmem_rd_en for KTAPS consecutive cycles, with addr incrementing by 1 each cycle. There is no multiplier: the address runs continuously across all kernels, so kernel (oc,ic) is at wbase+(oc*num_ic+ic)*9.
  - eng_w_we, eng_w_idx and eng_w_data are driven exactly 1 cycle after each read.
  - Taps are written in order 0..8; the last write occurs KTAPS+1 cycles after entry.
  - Then go START.
- State START:
  - eng_frm_start=1 for one cycle.
  - eng_acc_clr=(ic==0) and eng_acc_last=(ic==num_ic-1). Both are held steady from LOAD_W entry through RUN.
  - Go RUN.
- State RUN:
  - A beat is counted when obs_tvalid && obs_tready.
  - A beat with obs_tlast and count==FRAME_PIX-1 ends the frame normally → NEXT.
  - tlast on any other beat, or count reaching FRAME_PIX-1 without tlast, sets err → DONE.
- State NEXT:
  - If ic<num_ic-1: ic++.
  - Else ic=0 and oc++; if oc was num_oc-1 → DONE.
  - Otherwise → LOAD_W.
- State DONE: done=1 for one cycle → IDLE.
- cfg_abort: in any non-IDLE state, go to IDLE next cycle. No done pulse, err unchanged; wmem and engine strobes are forced to 0 that cycle.
- cfg_start while busy: ignored.
- cfg_start and cfg_abort in the same IDLE cycle: abort has priority, so the start is ignored.
- Backpressure: stalls on obs_tready only extend RUN; no beat is counted twice.
- Overhead per pass, excluding the frame itself: KTAPS+3 cycles.

Optional Feature:
- Macro CONV_SEQ_PERF_EN.
- When defined, adds these outputs:
  - perf_run_cyc [31:0]: cycles spent in RUN.
  - perf_stall_cyc [31:0]: RUN cycles with obs_tvalid && !obs_tready.
  - Both are cleared on accepted cfg_start and saturate at all-ones.
- When undefined, these ports and their logic are absent.

Decomposition:
- Shared package conv_pkg:
  - state enum (IDLE, LOAD_W, START, RUN, NEXT, DONE);
  - constants IMG_W=128, IMG_H=128, FRAME_PIX, KTAPS, PIX_DATA_W=16.
- Natural sub-module conv_wload: the LOAD_W tap counter, read strobe and 1-cycle delayed engine write. Interface is start, done, addr in/out, read and write ports.

Test Plan:
- num_ic=1, num_oc=1, wbase=0x0100; memory holds tap value = address; engine returns 16384 beats with tlast on the last → 9 reads at 0x0100..0x0108; eng_w_idx 0..8 with data 0x0100..0x0108; acc_clr=acc_last=1; one frm_start; done once; err=0.
- num_ic=3, num_oc=2, wbase=0 → 6 passes in order (oc,ic) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2). Kernel addresses start at 0, 9, 18, 27, 36, 45. acc_clr is high on ic=0 passes only; acc_last on ic=2 passes only.
- Same as the first case, but obs_tready toggles 50% randomly → the frame completes after exactly 16384 accepted beats; no early advance.
- tlast on beat 100 → err=1, done pulse, IDLE. A following cfg_start clears err and runs normally.
- cfg_abort on the 5th RUN beat → busy=0 next cycle; no done; all strobes 0. A later start repeats from ic=oc=0.
- num_ic=0, num_oc=0 → behaves as 1×1: one pass, then done. With CONV_SEQ_PERF_EN defined, perf_stall_cyc equals the injected stall count.
